// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage issuing one- or two-word data-memory accesses with timeout and writeback
module memory_access_stage #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       Data,
  input  logic [31:0]       Address,
  input  logic [2:0]        WB_Address,
  input  logic              MR,
  input  logic              MW,
  input  logic              WB,
  input  logic              JWSP,
  input  logic              Stack_PC,
  input  logic              Stack_Flags,
  input  logic [2:0]        Final_Flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              Stall,
  output logic              WB_Out,
  output logic [2:0]        WB_Address_Out,
  output logic [15:0]       WB_Data,
  output logic [31:0]       PC_Out,
  output logic              PC_Valid,
  output logic [2:0]        Flags_Restore,
  output logic              Flags_Restore_Valid,
  output logic              Mem_Error
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [31:0] l_data;
  logic [ADDR_W-1:0] l_addr;
  logic [2:0] l_wa, l_ff;
  logic l_mr, l_mw, l_wb, l_spc, l_sfl;
  logic [15:0] pc_hi;
  logic memop, acc, tmo;
  logic unused_ok;
  assign unused_ok = JWSP;
  always_comb begin
    memop = in_valid & (MR ^ MW);
    acc = (state == ACC_HI) || (state == ACC_LO);
    tmo = acc && !mem_ack && (cnt == CW'(MEM_TIMEOUT - 1));
    mem_req = acc;
    mem_we = acc & l_mw;
    mem_addr = (state == ACC_LO && l_spc) ? l_addr - 1'b1 : l_addr;
    mem_wdata = (state == ACC_HI) ? l_data[31:16] : (l_sfl && !l_spc) ? {13'b0, l_ff} : l_data[15:0];
    Stall = ((state == IDLE && memop) || state == ACC_HI || (state == ACC_LO && !mem_ack)) && !tmo;
    nxt = tmo ? IDLE
        : (state == IDLE)   ? (memop ? (Stack_PC ? ACC_HI : ACC_LO) : IDLE)
        : (state == ACC_HI) ? (mem_ack ? ACC_LO : ACC_HI)
        : (state == ACC_LO) ? (mem_ack ? DONE : ACC_LO)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && memop) begin
      l_data <= Data;
      l_addr <= Address[ADDR_W-1:0];
      l_wa <= WB_Address;
      l_ff <= Final_Flags;
      l_mr <= MR;
      l_mw <= MW;
      l_wb <= WB;
      l_spc <= Stack_PC;
      l_sfl <= Stack_Flags;
    end
    if (state == ACC_HI && mem_ack) pc_hi <= mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      Mem_Error <= 1'b0;
      WB_Out <= 1'b0;
      WB_Address_Out <= '0;
      WB_Data <= '0;
      PC_Out <= '0;
      PC_Valid <= 1'b0;
      Flags_Restore <= '0;
      Flags_Restore_Valid <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (acc && nxt == state) ? cnt + 1'b1 : '0;
      WB_Out <= 1'b0;
      PC_Valid <= 1'b0;
      Flags_Restore_Valid <= 1'b0;
      if (tmo) Mem_Error <= 1'b1;
      if (state == IDLE && in_valid && !memop) begin
        WB_Out <= WB;
        WB_Address_Out <= WB_Address;
        WB_Data <= Data[15:0];
      end
      if (state == ACC_LO && mem_ack) begin
        WB_Out <= l_mr & l_wb;
        WB_Address_Out <= l_wa;
        WB_Data <= mem_rdata;
        PC_Out <= {pc_hi, mem_rdata};
        PC_Valid <= l_mr & l_spc;
        Flags_Restore <= mem_rdata[2:0];
        Flags_Restore_Valid <= l_mr & l_sfl;
      end
    end
  end
endmodule
